// File: rtl/counter_mode_p_if.sv
// Control/status bundle for counter_mode_p: run controls and settings in, count and flags out.
// The master side drives controls; the slave side is the counter itself.
interface counter_mode_p_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             stop;
    logic             en;
    logic             mode;
    logic             dir;
    logic [WIDTH-1:0] init;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic             tick;

    modport master (
        output start, stop, en, mode, dir, init, limit,
        input  count, busy, done, tick
    );

    modport slave (
        input  start, stop, en, mode, dir, init, limit,
        output count, busy, done, tick
    );
endinterface

// File: rtl/counter_mode_p.sv
// Programmable up/down counter with one-shot or auto-reload runs, started on a rising edge
// of start; settings are latched at that edge so later input changes cannot disturb a run.
module counter_mode_p #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           nrst,
    counter_mode_p_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] count_reg, count_next;
    logic [WIDTH-1:0] init_reg, limit_reg;
    logic             mode_reg, dir_reg;
    logic             start_q;

    logic start_edge;
    logic capture;
    logic free_run;
    logic at_limit;

    assign start_edge = bus.start & ~start_q;
    assign capture    = start_edge & ~bus.stop;
    // A run whose terminal value equals its start value never terminates.
    assign free_run   = (init_reg == limit_reg);
    assign at_limit   = (count_reg == limit_reg);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_reg <= IDLE;
            count_reg <= '0;
            start_q   <= 1'b0;
            init_reg  <= '0;
            limit_reg <= '0;
            mode_reg  <= 1'b0;
            dir_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            start_q   <= bus.start;
            if (capture) begin
                init_reg  <= bus.init;
                limit_reg <= bus.limit;
                mode_reg  <= bus.mode;
                dir_reg   <= bus.dir;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        if (bus.stop) begin
            state_next = IDLE;
        end else if (start_edge) begin
            state_next = RUN;
            count_next = bus.init;
        end else if (state_reg == RUN && bus.en) begin
            if (at_limit && !free_run) begin
                if (mode_reg) begin
                    count_next = init_reg;
                end else begin
                    state_next = DONE;
                end
            end else if (dir_reg) begin
                count_next = count_reg - ONE;
            end else begin
                count_next = count_reg + ONE;
            end
        end
    end

    assign bus.count = count_reg;
    assign bus.busy  = (state_reg == RUN);
    assign bus.done  = (state_reg == DONE);
    assign bus.tick  = (state_reg == RUN) & bus.en & at_limit & ~free_run
                     & ~bus.stop & ~start_edge;
endmodule

// File: tb/tb_counter_mode_p.sv
// Scoreboard bench for counter_mode_p: each cycle's expected outputs are queued as stimulus
// is applied and popped when outputs are sampled on the falling clock edge.
module tb_counter_mode_p;
    logic clk  = 1'b0;
    logic nrst = 1'b0;

    counter_mode_p_if #(.WIDTH(8)) bus();

    counter_mode_p #(.WIDTH(8)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] count;
        logic       busy;
        logic       done;
        logic       tick;
    } obs_t;

    typedef struct packed {
        logic start;
        logic stop;
        logic en;
        obs_t o;
    } row_t;

    obs_t exp_q[$];
    int   total  = 0;
    int   passed = 0;

    function automatic row_t mk(logic s, logic p, logic e, int c, logic b, logic d, logic t);
        row_t r;
        r.start   = s;
        r.stop    = p;
        r.en      = e;
        r.o.count = 8'(c);
        r.o.busy  = b;
        r.o.done  = d;
        r.o.tick  = t;
        return r;
    endfunction

    function automatic obs_t sample_outputs();
        obs_t s;
        s.count = bus.count;
        s.busy  = bus.busy;
        s.done  = bus.done;
        s.tick  = bus.tick;
        return s;
    endfunction

    task automatic set_cfg(logic m, logic d, int i, int l);
        bus.mode  = m;
        bus.dir   = d;
        bus.init  = 8'(i);
        bus.limit = 8'(l);
    endtask

    task automatic test_reset();
        obs_t got, e;
        // Outputs after the first clock seen under reset.
        exp_q.push_back(obs_t'(0));
        @(negedge clk);
        got = sample_outputs();
        e   = exp_q.pop_front();
        total++;
        if (got !== e)
            $display("FAIL reset_hold: got count=%0d busy=%b done=%b tick=%b, expected count=%0d busy=%b done=%b tick=%b",
                     got.count, got.busy, got.done, got.tick, e.count, e.busy, e.done, e.tick);
        else passed++;
        #2 nrst = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back(obs_t'(0));
        @(negedge clk);
        got = sample_outputs();
        e   = exp_q.pop_front();
        total++;
        if (got !== e)
            $display("FAIL reset_idle: got count=%0d busy=%b done=%b tick=%b, expected count=%0d busy=%b done=%b tick=%b",
                     got.count, got.busy, got.done, got.tick, e.count, e.busy, e.done, e.tick);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_one_shot();
        row_t rows[$];
        obs_t got, e;
        set_cfg(1'b0, 1'b0, 3, 7);
        rows.push_back(mk(1, 0, 1, 0, 0, 0, 0));
        rows.push_back(mk(0, 0, 1, 3, 1, 0, 0));
        rows.push_back(mk(0, 0, 1, 4, 1, 0, 0));
        rows.push_back(mk(0, 0, 1, 5, 1, 0, 0));
        rows.push_back(mk(0, 0, 1, 6, 1, 0, 0));
        rows.push_back(mk(0, 0, 1, 7, 1, 0, 1));
        rows.push_back(mk(0, 0, 1, 7, 0, 1, 0));
        rows.push_back(mk(0, 0, 0, 7, 0, 1, 0));
        rows.push_back(mk(0, 0, 1, 7, 0, 1, 0));
        for (int i = 0; i < rows.size(); i++) begin
            bus.start = rows[i].start;
            bus.stop  = rows[i].stop;
            bus.en    = rows[i].en;
            exp_q.push_back(rows[i].o);
            @(negedge clk);
            got = sample_outputs();
            e   = exp_q.pop_front();
            total++;
            if (got !== e)
                $display("FAIL one_shot cyc%0d: got count=%0d busy=%b done=%b tick=%b, expected count=%0d busy=%b done=%b tick=%b",
                         i, got.count, got.busy, got.done, got.tick, e.count, e.busy, e.done, e.tick);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_auto_reload();
        row_t rows[$];
        obs_t got, e;
        set_cfg(1'b1, 1'b0, 2, 4);
        // Restart straight from DONE; start is held high to show the level does not retrigger.
        rows.push_back(mk(1, 0, 1, 7, 0, 1, 0));
        for (int k = 0; k < 4; k++) begin
            rows.push_back(mk(1, 0, 1, 2, 1, 0, 0));
            rows.push_back(mk(1, 0, 1, 3, 1, 0, 0));
            if (k < 3) rows.push_back(mk(1, 0, 1, 4, 1, 0, 1));
        end
        // Stop on the terminal cycle suppresses tick; IDLE then holds count.
        rows.push_back(mk(0, 1, 1, 4, 1, 0, 0));
        rows.push_back(mk(0, 0, 1, 4, 0, 0, 0));
        rows.push_back(mk(0, 0, 1, 4, 0, 0, 0));
        for (int i = 0; i < rows.size(); i++) begin
            bus.start = rows[i].start;
            bus.stop  = rows[i].stop;
            bus.en    = rows[i].en;
            exp_q.push_back(rows[i].o);
            @(negedge clk);
            got = sample_outputs();
            e   = exp_q.pop_front();
            total++;
            if (got !== e)
                $display("FAIL auto_reload cyc%0d: got count=%0d busy=%b done=%b tick=%b, expected count=%0d busy=%b done=%b tick=%b",
                         i, got.count, got.busy, got.done, got.tick, e.count, e.busy, e.done, e.tick);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_down_wrap();
        row_t rows[$];
        obs_t got, e;
        set_cfg(1'b0, 1'b1, 1, 254);
        rows.push_back(mk(1, 0, 1, 4, 0, 0, 0));
        rows.push_back(mk(0, 0, 1, 1, 1, 0, 0));
        rows.push_back(mk(0, 0, 1, 0, 1, 0, 0));
        rows.push_back(mk(0, 0, 1, 255, 1, 0, 0));
        rows.push_back(mk(0, 0, 1, 254, 1, 0, 1));
        rows.push_back(mk(0, 0, 1, 254, 0, 1, 0));
        rows.push_back(mk(0, 1, 1, 254, 0, 1, 0));
        rows.push_back(mk(0, 0, 1, 254, 0, 0, 0));
        for (int i = 0; i < rows.size(); i++) begin
            bus.start = rows[i].start;
            bus.stop  = rows[i].stop;
            bus.en    = rows[i].en;
            exp_q.push_back(rows[i].o);
            @(negedge clk);
            got = sample_outputs();
            e   = exp_q.pop_front();
            total++;
            if (got !== e)
                $display("FAIL down_wrap cyc%0d: got count=%0d busy=%b done=%b tick=%b, expected count=%0d busy=%b done=%b tick=%b",
                         i, got.count, got.busy, got.done, got.tick, e.count, e.busy, e.done, e.tick);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_free_run();
        obs_t got, e;
        set_cfg(1'b0, 1'b0, 5, 5);
        bus.start = 1'b1;
        bus.stop  = 1'b0;
        bus.en    = 1'b1;
        exp_q.push_back(mk(0, 0, 0, 254, 0, 0, 0).o);
        @(negedge clk);
        got = sample_outputs();
        e   = exp_q.pop_front();
        total++;
        if (got !== e)
            $display("FAIL free_run_start: got count=%0d busy=%b, expected count=%0d busy=%b",
                     got.count, got.busy, e.count, e.busy);
        else passed++;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < 260; i++) begin
            // Settings changed mid-run must be ignored until the next start edge.
            if (i == 1) set_cfg(1'b1, 1'b1, 0, 9);
            exp_q.push_back(mk(0, 0, 0, (5 + i) % 256, 1, 0, 0).o);
            @(negedge clk);
            got = sample_outputs();
            e   = exp_q.pop_front();
            total++;
            if (got !== e)
                $display("FAIL free_run cyc%0d: got count=%0d busy=%b done=%b tick=%b, expected count=%0d busy=%b done=%b tick=%b",
                         i, got.count, got.busy, got.done, got.tick, e.count, e.busy, e.done, e.tick);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_control();
        row_t rows[$];
        obs_t got, e;
        rows.push_back(mk(0, 0, 0, 9, 1, 0, 0));
        rows.push_back(mk(0, 0, 0, 9, 1, 0, 0));
        rows.push_back(mk(0, 0, 0, 9, 1, 0, 0));
        rows.push_back(mk(0, 0, 1, 9, 1, 0, 0));
        rows.push_back(mk(0, 0, 1, 10, 1, 0, 0));
        rows.push_back(mk(0, 1, 1, 11, 1, 0, 0));
        rows.push_back(mk(1, 0, 1, 11, 0, 0, 0));
        rows.push_back(mk(1, 0, 1, 10, 1, 0, 0));
        rows.push_back(mk(0, 0, 1, 11, 1, 0, 0));
        rows.push_back(mk(1, 1, 1, 12, 1, 0, 0));
        rows.push_back(mk(0, 0, 1, 12, 0, 0, 0));
        for (int i = 0; i < rows.size(); i++) begin
            if (i == 6) set_cfg(1'b0, 1'b0, 10, 20);
            bus.start = rows[i].start;
            bus.stop  = rows[i].stop;
            bus.en    = rows[i].en;
            exp_q.push_back(rows[i].o);
            @(negedge clk);
            got = sample_outputs();
            e   = exp_q.pop_front();
            total++;
            if (got !== e)
                $display("FAIL control cyc%0d: got count=%0d busy=%b done=%b tick=%b, expected count=%0d busy=%b done=%b tick=%b",
                         i, got.count, got.busy, got.done, got.tick, e.count, e.busy, e.done, e.tick);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_async_reset();
        obs_t got, e;
        obs_t want[4];
        want[0] = mk(0, 0, 0, 12, 0, 0, 0).o;
        want[1] = mk(0, 0, 0, 3, 1, 0, 0).o;
        want[2] = obs_t'(0);
        want[3] = mk(0, 0, 0, 50, 1, 0, 0).o;
        set_cfg(1'b0, 1'b0, 3, 7);
        bus.en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) bus.start = 1'b1;
            if (i == 1) bus.start = 1'b0;
            if (i == 2) begin
                // Assert reset between edges with start held high through release.
                #2;
                bus.start = 1'b1;
                bus.init  = 8'd50;
                nrst      = 1'b0;
                #1;
            end
            exp_q.push_back(want[i]);
            if (i != 2) @(negedge clk);
            got = sample_outputs();
            e   = exp_q.pop_front();
            total++;
            if (got !== e)
                $display("FAIL async_reset step%0d: got count=%0d busy=%b done=%b tick=%b, expected count=%0d busy=%b done=%b tick=%b",
                         i, got.count, got.busy, got.done, got.tick, e.count, e.busy, e.done, e.tick);
            else passed++;
            if (i == 2) begin
                @(negedge clk); #1;
                nrst = 1'b1;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.en    = 1'b0;
        set_cfg(1'b0, 1'b0, 0, 0);
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_down_wrap();
        test_free_run();
        test_control();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end
endmodule
